regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_init_ctrl.sv | 62 ++++++
 rtl/regfile_mp.sv | 127 ++++++++++++
 tb/tb_regfile_mp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    // Initialisation controller states: INIT sweeps zeros, READY serves ports.
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Smallest address width able to index 'depth' entries (ceil(log2)).
    function automatic int addr_width(input int depth);
        int w;
        w = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < depth) begin
                w = i + 32'sd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_init_ctrl.sv
// Sweep controller: after reset or a clear request, walks every entry once
// to zero it, then reports READY until the next clear.
module regfile_init_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          sweep_en,
    output logic [AW-1:0] sweep_addr,
    output logic          init_ready
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 32'sd1);

    state_t        state_r;
    logic [AW-1:0] cnt_r;
    logic          init_ready_r;

    // State, sweep counter and ready flag; clr only matters once READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= INIT;
            cnt_r        <= '0;
            init_ready_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    if (cnt_r == LAST_ADDR) begin
                        state_r      <= READY;
                        cnt_r        <= '0;
                        init_ready_r <= 1'b1;
                    end else begin
                        cnt_r        <= cnt_r + 1'b1;
                    end
                end
                READY: begin
                    if (clr) begin
                        state_r      <= INIT;
                        cnt_r        <= '0;
                        init_ready_r <= 1'b0;
                    end else begin
                        state_r      <= READY;
                    end
                end
                default: begin
                    state_r      <= INIT;
                    cnt_r        <= '0;
                    init_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_en   = (state_r == INIT);
    assign sweep_addr = cnt_r;
    assign init_ready = init_ready_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NWR write ports (highest port wins on conflict),
// NRD registered read ports with write-first forwarding, optional hardwired
// zero entry, and a zeroing sweep after reset or clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                init_ready,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata
);

    logic          sweep_en_s;
    logic [AW-1:0] sweep_addr_s;

    logic [XLEN-1:0] mem_r   [NREGS];
    logic [XLEN-1:0] rdata_r [NRD];

    logic [AW-1:0]   waddr_s [NWR];
    logic [XLEN-1:0] wdata_s [NWR];
    logic [AW-1:0]   raddr_s [NRD];
    logic [NWR-1:0]  wvalid_s;
    logic [XLEN-1:0] rval_s  [NRD];

    regfile_init_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_init_ctrl (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .sweep_en   (sweep_en_s),
        .sweep_addr (sweep_addr_s),
        .init_ready (init_ready)
    );

    // An address is storable/readable if in range and not the hardwired zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 32'sd0) && (a == '0));
    endfunction

    // Unpack the flat port buses and qualify each write port.
    always_comb begin
        wvalid_s = '0;
        for (int i = 32'sd0; i < NWR; i++) begin
            waddr_s[i]  = waddr[i*AW +: AW];
            wdata_s[i]  = wdata[i*XLEN +: XLEN];
            wvalid_s[i] = we[i] && !sweep_en_s && !rst && addr_ok(waddr_s[i]);
        end
        for (int j = 32'sd0; j < NRD; j++) begin
            raddr_s[j] = raddr[j*AW +: AW];
        end
    end

    // Storage: sweep zeroing in INIT, otherwise port writes in ascending
    // order so the last (highest-indexed) matching port takes effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep_en_s) begin
                mem_r[sweep_addr_s] <= '0;
            end else begin
                for (int i = 32'sd0; i < NWR; i++) begin
                    if (wvalid_s[i]) begin
                        mem_r[waddr_s[i]] <= wdata_s[i];
                    end
                end
            end
        end
    end

    // Read value per lane: storage, overridden by the winning same-cycle write.
    always_comb begin
        for (int j = 32'sd0; j < NRD; j++) begin
            rval_s[j] = '0;
            if (addr_ok(raddr_s[j])) begin
                rval_s[j] = mem_r[raddr_s[j]];
            end else begin
                rval_s[j] = '0;
            end
            for (int i = 32'sd0; i < NWR; i++) begin
                if (wvalid_s[i] && (waddr_s[i] == raddr_s[j])) begin
                    rval_s[j] = wdata_s[i];
                end else begin
                    rval_s[j] = rval_s[j];
                end
            end
        end
    end

    // Registered read lanes: cleared by reset, held at zero during the sweep,
    // updated only on enabled reads.
    always_ff @(posedge clk) begin
        if (rst || sweep_en_s) begin
            for (int j = 32'sd0; j < NRD; j++) begin
                rdata_r[j] <= '0;
            end
        end else begin
            for (int j = 32'sd0; j < NRD; j++) begin
                if (re[j]) begin
                    rdata_r[j] <= rval_s[j];
                end
            end
        end
    end

    // Repack the read lanes onto the flat output bus.
    always_comb begin
        rdata = '0;
        for (int j = 32'sd0; j < NRD; j++) begin
            rdata[j*XLEN +: XLEN] = rdata_r[j];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected read data per
// lane, a monitor pops and compares one cycle after each committed read.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [1:0]  we, re, re_z;
    logic [9:0]  waddr, raddr;
    logic [63:0] wdata;
    logic        init_ready, init_ready_z;
    logic [63:0] rdata, rdata_z;

    int total = 0;
    int bad   = 0;
    int n;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] qz[$];

    logic [1:0] fire;
    logic       firez;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .init_ready(init_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst(rst), .clr(clr), .init_ready(init_ready_z),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re_z), .raddr(raddr), .rdata(rdata_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of port activity, applied at a negedge and held to the next.
    task automatic drive(input logic [1:0] w, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [1:0] r, input logic [4:0] ra0, input logic [4:0] ra1);
        we = w; waddr = {wa1, wa0}; wdata = {wd1, wd0};
        re = r; raddr = {ra1, ra0};
        @(negedge clk);
    endtask

    task automatic idle_sig();
        we = 2'b00; waddr = 10'd0; wdata = 64'd0; re = 2'b00; raddr = 10'd0; re_z = 2'b00; clr = 1'b0;
    endtask

    // Wait for init_ready while hammering writes/reads/clr that must be ignored.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!init_ready && cnt < 100) begin
            we = 2'b11; waddr = {5'd2, 5'd1}; wdata = {32'hBAD0_0002, 32'hBAD0_0001};
            re = 2'b11; raddr = {5'd2, 5'd1}; clr = 1'b1;
            @(negedge clk);
            cnt++;
        end
        idle_sig();
    endtask

    // Monitor: a read commits at a posedge when enabled, READY and not in reset.
    always begin
        @(posedge clk);
        fire  = re & {2{init_ready}} & {2{~rst}};
        firez = re_z[0] & init_ready_z & ~rst;
        @(negedge clk);
        if (fire[0]) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL lane0_unexpected: got %h expected no read", rdata[31:0]);
            end else check("lane0", rdata[31:0], q0.pop_front());
        end
        if (fire[1]) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL lane1_unexpected: got %h expected no read", rdata[63:32]);
            end else check("lane1", rdata[63:32], q1.pop_front());
        end
        if (firez) begin
            if (qz.size() == 0) begin
                total++; bad++;
                $display("FAIL z_lane0_unexpected: got %h expected no read", rdata_z[31:0]);
            end else check("z_lane0", rdata_z[31:0], qz.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_sig();
        @(negedge clk);
        check("rst_init_ready", {31'd0, init_ready}, 32'd0);
        check("rst_rdata0", rdata[31:0], 32'd0);
        check("rst_rdata1", rdata[63:32], 32'd0);
        rst = 1'b0;
        wait_ready(n);
        check("init_latency", n, 32'd32);
        check("init_rdata0", rdata[31:0], 32'd0);
        check("init_rdata1", rdata[63:32], 32'd0);

        // All entries zero after the first sweep.
        for (int a = 0; a < 32; a += 2) begin
            q0.push_back(32'd0); q1.push_back(32'd0);
            drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b11, 5'(a), 5'(a + 1));
        end

        // Simple write then read.
        drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00, 5'd0, 5'd0);
        q0.push_back(32'hDEADBEEF);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 5'd5, 5'd0);

        // Same-address write conflict, forwarded on both lanes.
        q0.push_back(32'h22); q1.push_back(32'h22);
        drive(2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 2'b11, 5'd7, 5'd7);
        q0.push_back(32'h22);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 5'd7, 5'd0);

        // Entry 0: hardwired zero vs ordinary register.
        drive(2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0, 2'b00, 5'd0, 5'd0);
        q0.push_back(32'd0); qz.push_back(32'hFFFFFFFF);
        re_z = 2'b01;
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 5'd0, 5'd0);
        q0.push_back(32'd0); qz.push_back(32'h12345678);
        drive(2'b01, 5'd0, 5'd0, 32'h12345678, 32'd0, 2'b01, 5'd0, 5'd0);
        re_z = 2'b00;

        // Port 1 forwarded onto lane 0, then hold with re=0.
        q0.push_back(32'hA5A5A5A5);
        drive(2'b10, 5'd0, 5'd9, 32'd0, 32'hA5A5A5A5, 2'b01, 5'd9, 5'd0);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 5'd3, 5'd3);
        check("hold_lane0", rdata[31:0], 32'hA5A5A5A5);

        // Fill x1..x31 and read some back.
        for (int a = 1; a < 32; a++) begin
            drive(2'b01, 5'(a), 5'd0, 32'h100 + 32'(a), 32'd0, 2'b00, 5'd0, 5'd0);
        end
        q0.push_back(32'h101); q1.push_back(32'h11F);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b11, 5'd1, 5'd31);
        q0.push_back(32'h105); q1.push_back(32'h107);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b11, 5'd5, 5'd7);

        // Clear: the clr cycle still reads, then a 32-cycle sweep.
        clr = 1'b1;
        q0.push_back(32'h103);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 5'd3, 5'd0);
        clr = 1'b0;
        check("clr_init_ready_low", {31'd0, init_ready}, 32'd0);
        wait_ready(n);
        check("clr_latency", n, 32'd32);
        check("clr_rdata0", rdata[31:0], 32'd0);
        qz.push_back(32'd0); q0.push_back(32'd0);
        re_z = 2'b01;
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 5'd0, 5'd0);
        re_z = 2'b00;
        for (int a = 0; a < 32; a += 2) begin
            q0.push_back(32'd0); q1.push_back(32'd0);
            drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b11, 5'(a), 5'(a + 1));
        end

        // Reset while READY with traffic: rdata cleared, sweep restarts.
        drive(2'b01, 5'd4, 5'd0, 32'h44, 32'd0, 2'b00, 5'd0, 5'd0);
        q0.push_back(32'h44);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 5'd4, 5'd0);
        rst = 1'b1;
        drive(2'b01, 5'd6, 5'd0, 32'h66, 32'd0, 2'b01, 5'd4, 5'd0);
        rst = 1'b0;
        check("rst_ready_rdata0", rdata[31:0], 32'd0);
        check("rst_ready_init_low", {31'd0, init_ready}, 32'd0);
        wait_ready(n);
        check("rst_ready_latency", n, 32'd32);

        // Reset at sweep cycle 10 of a clear: sweep restarts from zero.
        drive(2'b01, 5'd4, 5'd0, 32'h44, 32'd0, 2'b00, 5'd0, 5'd0);
        clr = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midsweep_init_low", {31'd0, init_ready}, 32'd0);
        wait_ready(n);
        check("midsweep_latency", n, 32'd32);
        q0.push_back(32'd0); q1.push_back(32'd0);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b11, 5'd4, 5'd31);

        idle_sig();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q0.size() + q1.size() + qz.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
